// File: rtl/gcm_payload_aligner.sv
// gcm_payload_aligner
//   Strips a SHIFT_BYTES header from the front of each packet, realigns the
//   payload so it starts at byte 0 of every output beat, XORs it with the
//   keystream word captured from the matching input beat and emits a packed
//   ciphertext stream for GHASH. Byte 0 of a beat is its most significant byte.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     input beat handshake
//   s_sop/s_eop         first/last input beat of a packet
//   s_nbytes            valid bytes in the eop beat (1..DB)
//   s_data, s_ks        packet bytes and per-beat keystream
//   s_meta              sideband, captured on the sop beat
//   m_valid/m_ready     output beat handshake (single register stage)
//   m_sop/m_eop         first/last ciphertext beat
//   m_nbytes            valid bytes in the m_eop beat, DB otherwise
//   m_data              aligned ciphertext, bytes >= m_nbytes zeroed
//   m_meta              sideband of the current packet
//   o_err               one-cycle pulse on a framing error
module gcm_payload_aligner #(
    parameter int DATA_W      = 256,
    parameter int SHIFT_BYTES = 2,
    parameter int META_W      = 33,
    localparam int NB_W       = $clog2(DATA_W/8) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic [NB_W-1:0]   s_nbytes,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] s_ks,
    input  logic [META_W-1:0] s_meta,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sop,
    output logic              m_eop,
    output logic [NB_W-1:0]   m_nbytes,
    output logic [DATA_W-1:0] m_data,
    output logic [META_W-1:0] m_meta,
    output logic              o_err
);
    localparam int DB     = DATA_W / 8;
    localparam int S      = SHIFT_BYTES;
    localparam int HEAD_W = 8 * S;        // bytes 0..S-1 of a beat
    localparam int RES_W  = DATA_W - HEAD_W; // bytes S..DB-1 of a beat
    localparam logic [NB_W-1:0] DB_NB = NB_W'(DB);
    localparam logic [NB_W-1:0] S_NB  = NB_W'(S);

    typedef enum logic [1:0] {IDLE = 2'd0, MID = 2'd1, FLUSH = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [RES_W-1:0]    res_q, res_d;     // tail of the previous input beat
    logic [DATA_W-1:0]   ks_q, ks_d;       // keystream of the previous input beat
    logic [NB_W-1:0]     fnb_q, fnb_d;     // byte count of the pending flush beat
    logic                first_q, first_d; // next emitted beat is the packet's first
    logic                mv_q, mv_d;
    logic                msop_q, msop_d;
    logic                meop_q, meop_d;
    logic [NB_W-1:0]     mnb_q, mnb_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic                err_q, err_d;

    logic                out_free;
    logic                acc;
    logic                start_pkt;
    logic                emit;
    logic                emit_eop;
    logic [NB_W-1:0]     emit_nb;
    logic [DATA_W-1:0]   emit_raw;
    logic [DATA_W-1:0]   emit_masked;

    assign out_free = !mv_q || m_ready;
    assign s_ready  = (state_q != FLUSH) && out_free;
    assign acc      = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        ks_d      = ks_q;
        fnb_d     = fnb_q;
        first_d   = first_q;
        mv_d      = mv_q && !m_ready;
        msop_d    = msop_q;
        meop_d    = meop_q;
        mnb_d     = mnb_q;
        mdata_d   = mdata_q;
        meta_d    = meta_q;
        err_d     = 1'b0;
        start_pkt = 1'b0;
        emit      = 1'b0;
        emit_eop  = 1'b0;
        emit_nb   = DB_NB;
        emit_raw  = '0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (s_sop) start_pkt = 1'b1;
                    else       err_d     = 1'b1;   // stray beat is dropped
                end
            end
            MID: begin
                if (acc) begin
                    if (s_sop) begin
                        // Abort the held packet: its residue is discarded unsent.
                        err_d     = 1'b1;
                        start_pkt = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_raw = {res_q, s_data[DATA_W-1 -: HEAD_W]} ^ ks_q;
                        if (s_eop && s_nbytes <= S_NB) begin
                            // Tail fits in this beat: no flush needed.
                            emit_nb  = DB_NB - S_NB + s_nbytes;
                            emit_eop = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            res_d = s_data[RES_W-1:0];
                            ks_d  = s_ks;
                            if (s_eop) begin
                                fnb_d   = s_nbytes - S_NB;
                                state_d = FLUSH;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    emit     = 1'b1;
                    emit_raw = {res_q, {HEAD_W{1'b0}}} ^ ks_q;
                    emit_nb  = fnb_q;
                    emit_eop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_pkt) begin
            meta_d  = s_meta;
            first_d = 1'b1;
            if (s_eop && s_nbytes <= S_NB) begin
                state_d = IDLE;               // header only, nothing to emit
            end else begin
                res_d = s_data[RES_W-1:0];
                ks_d  = s_ks;
                if (s_eop) begin
                    fnb_d   = s_nbytes - S_NB;
                    state_d = FLUSH;
                end else begin
                    state_d = MID;
                end
            end
        end

        // Zero every byte at or beyond the beat's valid count.
        emit_masked = emit_raw;
        for (int i = 0; i < DB; i++) begin
            if (i >= int'(emit_nb)) emit_masked[DATA_W-1-8*i -: 8] = 8'h00;
        end

        if (emit) begin
            mv_d    = 1'b1;
            msop_d  = first_q;
            first_d = 1'b0;
            meop_d  = emit_eop;
            mnb_d   = emit_nb;
            mdata_d = emit_masked;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            ks_q    <= '0;
            fnb_q   <= '0;
            first_q <= 1'b0;
            mv_q    <= 1'b0;
            msop_q  <= 1'b0;
            meop_q  <= 1'b0;
            mnb_q   <= '0;
            mdata_q <= '0;
            meta_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ks_q    <= ks_d;
            fnb_q   <= fnb_d;
            first_q <= first_d;
            mv_q    <= mv_d;
            msop_q  <= msop_d;
            meop_q  <= meop_d;
            mnb_q   <= mnb_d;
            mdata_q <= mdata_d;
            meta_q  <= meta_d;
            err_q   <= err_d;
        end
    end

    assign m_valid  = mv_q;
    assign m_sop    = msop_q;
    assign m_eop    = meop_q;
    assign m_nbytes = mnb_q;
    assign m_data   = mdata_q;
    assign m_meta   = meta_q;
    assign o_err    = err_q;
endmodule

// File: tb/tb_gcm_payload_aligner.sv
// Testbench for gcm_payload_aligner (DATA_W=256, SHIFT_BYTES=2).
// The reference model collects each packet's bytes and keystream words and
// derives output beats directly from payload byte offsets.
module tb_gcm_payload_aligner;
    localparam int DATA_W = 256;
    localparam int S      = 2;
    localparam int META_W = 33;
    localparam int DB     = 32;
    localparam int NB_W   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid, s_ready, s_sop, s_eop;
    logic [NB_W-1:0]   s_nbytes;
    logic [DATA_W-1:0] s_data, s_ks;
    logic [META_W-1:0] s_meta;
    logic              m_valid, m_ready, m_sop, m_eop;
    logic [NB_W-1:0]   m_nbytes;
    logic [DATA_W-1:0] m_data;
    logic [META_W-1:0] m_meta;
    logic              o_err;

    always #5 clk = ~clk;

    gcm_payload_aligner #(.DATA_W(DATA_W), .SHIFT_BYTES(S), .META_W(META_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop),
        .s_nbytes(s_nbytes), .s_data(s_data), .s_ks(s_ks), .s_meta(s_meta),
        .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
        .m_nbytes(m_nbytes), .m_data(m_data), .m_meta(m_meta), .o_err(o_err)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                nb;
        bit                sop;
        bit                eop;
        logic [META_W-1:0] meta;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // model state
    beat_t             expq[$];
    logic [7:0]        pbytes[$];
    logic [DATA_W-1:0] pks[$];
    bit                active = 0;
    int                pushed = 0;
    logic [META_W-1:0] pmeta = '0;
    bit                err_exp = 0;
    int                err_want = 0, err_seen = 0;
    int                beats_seen = 0, eop_cnt = 0;
    logic [DATA_W-1:0] last_eop_data = '0;
    int                last_eop_nb = 0;
    bit                last_eop_sop = 0;
    int                rdy_mode = 1;   // 0 random, 1 high, 2 low

    // monitor history for stall stability
    bit                prev_stall = 0;
    logic [DATA_W-1:0] pd;
    logic [NB_W-1:0]   pn;
    logic              ps, pe;

    task automatic chk(input bit ok, input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic beat_t mk_beat(input int k, input int nb, input bit last);
        beat_t b;
        logic [DATA_W-1:0] kw;
        kw = pks[k];
        b.data = '0;
        for (int i = 0; i < nb; i++)
            b.data[DATA_W-1-8*i -: 8] = pbytes[S + k*DB + i] ^ kw[DATA_W-1-8*i -: 8];
        b.nb = nb; b.sop = (k == 0); b.eop = last; b.meta = pmeta;
        return b;
    endfunction

    task automatic model_accept();
        int nb, p, m;
        logic [DATA_W-1:0] d;
        d = s_data;
        if (s_sop) begin
            if (active) begin err_exp = 1; err_want++; end
            active = 1; pbytes.delete(); pks.delete(); pushed = 0; pmeta = s_meta;
        end else if (!active) begin
            err_exp = 1; err_want++;
            return;
        end
        nb = s_eop ? int'(s_nbytes) : DB;
        for (int i = 0; i < nb; i++) pbytes.push_back(d[DATA_W-1-8*i -: 8]);
        pks.push_back(s_ks);
        if (s_eop) begin
            p = pbytes.size() - S;
            if (p > 0) begin
                m = (p + DB - 1) / DB;
                for (int k = pushed; k < m; k++)
                    expq.push_back(mk_beat(k, (k == m-1) ? p - (m-1)*DB : DB, k == m-1));
            end
            active = 0;
        end else if (pks.size() >= 2) begin
            // more data follows, so this beat is full and not last
            expq.push_back(mk_beat(pks.size() - 2, DB, 1'b0));
            pushed = pks.size() - 1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            active = 0; pbytes.delete(); pks.delete(); expq.delete();
            err_exp = 0; prev_stall = 0;
        end else begin
            checks++;
            if (o_err !== err_exp) begin
                errors++;
                $display("FAIL o_err got %0b want %0b", o_err, err_exp);
            end
            if (o_err) err_seen++;
            if (prev_stall) begin
                checks++;
                if (!(m_valid && m_data == pd && m_nbytes == pn && m_sop == ps && m_eop == pe)) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b d=%h want d=%h", m_valid, m_data, pd);
                end
            end
            if (m_valid && !m_ready) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL s_ready_stall got %0b want 0", s_ready);
                end
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got d=%h nb=%0d want none", m_data, m_nbytes);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    if (m_data !== e.data || int'(m_nbytes) != e.nb || m_sop !== e.sop ||
                        m_eop !== e.eop || m_meta !== e.meta) begin
                        errors++;
                        $display("FAIL beat got d=%h nb=%0d sop=%0b eop=%0b meta=%h want d=%h nb=%0d sop=%0b eop=%0b meta=%h",
                                 m_data, m_nbytes, m_sop, m_eop, m_meta, e.data, e.nb, e.sop, e.eop, e.meta);
                    end
                end
                if (m_eop) begin
                    eop_cnt++; last_eop_data = m_data; last_eop_nb = int'(m_nbytes); last_eop_sop = m_sop;
                end
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data; pn = m_nbytes; ps = m_sop; pe = m_eop;
            err_exp = 0;
            if (s_valid && s_ready) model_accept();
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = ($urandom_range(0, 3) != 0);
                1:       m_ready = 1'b1;
                default: m_ready = 1'b0;
            endcase
        end
    end

    function automatic logic [DATA_W-1:0] rword();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W/32; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] ramp(input int base);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DB; i++) w[DATA_W-1-8*i -: 8] = 8'(base + i);
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input bit sop, input bit eop, input int nb, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] k, input logic [META_W-1:0] mt);
        bit f;
        int n;
        s_valid = 1; s_sop = sop; s_eop = eop; s_nbytes = NB_W'(nb);
        s_data = d; s_ks = k; s_meta = mt;
        f = 0; n = 0;
        while (!f && n < 300) begin
            @(negedge clk); f = s_ready;
            @(posedge clk); #1; n++;
        end
        if (!f) begin
            checks++; errors++;
            $display("FAIL send_timeout got s_ready=0 want 1");
        end
        s_valid = 0;
    endtask

    task automatic wait_eop(input int start);
        int n;
        n = 0;
        while (eop_cnt <= start && n < 200) begin @(posedge clk); #1; n++; end
        chk(eop_cnt > start, "eop_timeout", DATA_W'(eop_cnt), DATA_W'(start + 1));
    endtask

    task automatic rand_pkt(input int nbeats, input bit close);
        logic [META_W-1:0] mt;
        bit last;
        mt = META_W'({$urandom(), $urandom()});
        for (int b = 0; b < nbeats; b++) begin
            last = close && (b == nbeats - 1);
            send(b == 0, last, last ? $urandom_range(1, DB) : DB, rword(), rword(), mt);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic pkt_scn2();
        int e0, b0;
        e0 = eop_cnt; b0 = beats_seen;
        send(1, 0, DB, ramp(8'h00), '0, 33'h1_2345_6789);
        send(0, 0, DB, ramp(8'h20), '0, '0);
        send(0, 1, 2,  ramp(8'h40), '0, '0);
        wait_eop(e0);
        chk(last_eop_data == 256'h22232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f4041,
            "scn2_data", last_eop_data, 256'h22232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f4041);
        chk(last_eop_nb == 32, "scn2_nbytes", DATA_W'(last_eop_nb), DATA_W'(32));
        chk(beats_seen - b0 == 2, "scn2_beats", DATA_W'(beats_seen - b0), DATA_W'(2));
    endtask

    initial begin
        int e0, b0, r;
        logic [DATA_W-1:0] hold;
        rst = 1; s_valid = 0; s_sop = 0; s_eop = 0; s_nbytes = '0;
        s_data = '0; s_ks = '0; s_meta = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk(m_valid == 0 && m_sop == 0 && m_eop == 0 && o_err == 0, "reset_ctrl",
            DATA_W'({m_valid, m_sop, m_eop, o_err}), '0);
        chk(m_data == '0 && m_nbytes == '0 && m_meta == '0, "reset_data",
            m_data | DATA_W'(m_nbytes) | DATA_W'(m_meta), '0);
        chk(s_ready == 1, "reset_s_ready", DATA_W'(s_ready), DATA_W'(1));
        @(posedge clk); #1;

        // 1: single full beat, ks=0
        e0 = eop_cnt;
        send(1, 1, 32, ramp(8'h01), '0, 33'h0_0000_00AA);
        wait_eop(e0);
        chk(last_eop_data == 256'h030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f200000,
            "scn1_data", last_eop_data, 256'h030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f200000);
        chk(last_eop_nb == 30 && last_eop_sop, "scn1_nb_sop", DATA_W'(last_eop_nb), DATA_W'(30));

        // 2: tail fits, no flush
        pkt_scn2();

        // 3: tail spills, ks all-ones
        e0 = eop_cnt; b0 = beats_seen;
        send(1, 0, DB, ramp(8'h00), '1, '0);
        send(0, 0, DB, ramp(8'h20), '1, '0);
        send(0, 1, 10, ramp(8'h40), '1, '0);
        wait_eop(e0);
        chk(last_eop_data == {64'hbdbcbbbab9b8b7b6, 192'h0}, "scn3_data", last_eop_data, {64'hbdbcbbbab9b8b7b6, 192'h0});
        chk(last_eop_nb == 8, "scn3_nbytes", DATA_W'(last_eop_nb), DATA_W'(8));
        chk(beats_seen - b0 == 3, "scn3_beats", DATA_W'(beats_seen - b0), DATA_W'(3));

        // 4: downstream stall mid-packet
        e0 = eop_cnt;
        send(1, 0, DB, rword(), rword(), 33'h1_0000_0001);
        send(0, 0, DB, rword(), rword(), '0);
        fork
            begin
                send(0, 0, DB, rword(), rword(), '0);
                send(0, 0, DB, rword(), rword(), '0);
                send(0, 1, 20, rword(), rword(), '0);
            end
            begin
                rdy_mode = 2;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk(m_valid && !s_ready, "scn4_stall", DATA_W'({m_valid, s_ready}), DATA_W'(2'b10));
                hold = m_data;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk(m_valid && m_data == hold, "scn4_hold", m_data, hold);
                rdy_mode = 1;
            end
        join
        wait_eop(e0);

        // 5: header-only packet, then stray beat in IDLE
        b0 = beats_seen; e0 = err_seen;
        send(1, 1, 2, rword(), rword(), '0);
        idle(5);
        chk(beats_seen == b0 && err_seen == e0, "scn5_zero_payload", DATA_W'(beats_seen - b0), '0);
        send(0, 0, DB, rword(), rword(), '0);
        idle(3);
        chk(err_seen == e0 + 1 && beats_seen == b0, "scn5_stray", DATA_W'(err_seen - e0), DATA_W'(1));

        // 6: reset mid-packet, then repeat scenario 2
        send(1, 0, DB, rword(), rword(), '1);
        send(0, 0, DB, rword(), rword(), '0);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk(m_valid == 0 && s_ready == 1 && m_meta == '0, "scn6_reset",
            DATA_W'({m_valid, s_ready}), DATA_W'(2'b01));
        @(posedge clk); #1;
        pkt_scn2();

        // randomized traffic with backpressure, strays and aborts
        rdy_mode = 0;
        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) send(0, 0, DB, rword(), rword(), '0);
            if (r == 1) rand_pkt($urandom_range(1, 3), 0);
            rand_pkt($urandom_range(1, 4), 1);
        end
        rdy_mode = 1;
        idle(20);
        chk(expq.size() == 0, "drain", DATA_W'(expq.size()), '0);
        chk(err_seen == err_want, "err_count", DATA_W'(err_seen), DATA_W'(err_want));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
